wave_display_multi: RTL and testbench
=====================================

# wave_display_multi

Parametrised multi-channel waveform renderer for the VGA pixel path. For each pixel coordinate it reads per-channel sample RAMs (one-cycle synchronous read) and decides whether the pixel lies on a trace. It then emits a registered valid_pixel flag and a priority-resolved RGB colour. It adds line, dot and fill modes, tear-free frame-synchronous buffer switching, and up to four overlaid channels.

## Interface
- NUM_CH, 2: number of channels, 1..4.
- SAMPLE_W, 8: sample width in bits, 4..8.
- ADDR_W, 9: per-channel RAM address width; MSB selects the buffer, so each buffer holds 2^(ADDR_W-1) samples.
- X_START, 256: first x coordinate of the plot window.

- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- x  in  11  pixel column.
- y  in  10  pixel row.
- valid  in  1  x/y are in the active display area.
- read_index  in  1  buffer the writer has finished; sampled only at frame start.
- mode  in  2  trace style: 0 = line, 1 = dot, 2 = fill, 3 = line.
- ch_en  in  NUM_CH  per-channel enable; live, not latched.
- read_address  out  NUM_CH*ADDR_W  per-channel RAM address; channel k occupies bits [k*ADDR_W +: ADDR_W]; all channels carry the same value.
- read_value  in  NUM_CH*SAMPLE_W  per-channel RAM data, valid one clk after the address.
- valid_pixel  out  1  pixel lies on an enabled trace.
- r, g, b  out  8 each  pixel colour.

## Operation
- **Window**
  - xo = x - X_START (11-bit).
  - in_win = valid && x >= X_START && xo < 2^ADDR_W.
  - Each sample spans 2 pixels.
  - col = xo[ADDR_W-1:1].
- **Vertical bounds**
  - ys = y[SAMPLE_W:1].
  - in_y = (y >> (SAMPLE_W+1)) == 0.
- **Address**
  - read_address = {buf_sel, col}, combinational from x and buf_sel.
  - When not in_win, read_address = {buf_sel, 0}.
- **Buffer select**
  - buf_sel <= read_index on a clk edge where valid && x == 0 && y == 0.
  - Otherwise buf_sel holds its value.
  - A mid-frame change of read_index has no effect until the next frame start.
- **Stage 1** (registered, aligned with read_value)
  - Captures in_win, in_y, ys, col, and the new-column flag.
  - new_col = in_win && (col == 0 || col != last_col).
  - On new_col, per channel:
    - prev_val <= (col == 0) ? read_value_k : cur_val;
    - cur_val <= read_value_k;
    - last_col <= col.
  - The first column of each line therefore draws a point, never a link to the previous line.
- **Stage 2 hit test** (per channel k, using prev_val/cur_val after the stage-1 update)
  - lo = min(prev, cur), hi = max(prev, cur), MID = 2^(SAMPLE_W-1).
  - Line: lo <= ys <= hi (inclusive).
  - Dot: ys == cur.
  - Fill: min(cur, MID) <= ys <= max(cur, MID).
  - hit_k = ch_en[k] && in_win_s1 && in_y_s1 && test.
- **Colour**
  - Lowest-index channel with a hit wins.
  - Palette: ch0 FFFF00, ch1 00FFFF, ch2 FF00FF, ch3 00FF00.
  - No hit: valid_pixel = 0, rgb = 000000.
- **Comparisons** are unsigned at SAMPLE_W bits; no clamping is needed.

## Timing
- read_address: 0-cycle (combinational) from x.
- valid_pixel/r/g/b: registered, 2 clk edges after x/y/valid are presented (edge 1 captures stage 1, edge 2 captures the outputs).
- The pipeline runs every cycle; there is no stall and no backpressure.
- valid = 0 produces valid_pixel = 0 two cycles later.
- Reset (asynchronous, active-low):
  - valid_pixel = 0, r = g = b = 0.
  - buf_sel = 0, last_col = 0.
  - prev_val = cur_val = 0; all stage-1 flags cleared.
- Reset asserted mid-frame clears everything immediately. After release the outputs stay 0 for 2 cycles. buf_sel stays 0 until the next frame start.
- Simultaneous events:
  - Frame start with read_index change: buf_sel updates at that edge, and the address for the same cycle uses the old buf_sel. This is harmless because x = 0 is outside the default window.
  - Same-column repeat (odd x): no prev/cur update.

## Test plan
- **Reset:** hold reset = 0 with valid = 1 and arbitrary x/y, then release. Required: valid_pixel = 0 and rgb = 0 during reset and for 2 cycles after release.
- **Line mode, 2 channels:**
  - Setup: RAM0[0] = 0, RAM0[1] = 255; RAM1 all 0; mode = 0; ch_en = 2'b11.
  - Sweep x = 256, 257, 258 at y = 400 (ys = 200).
  - Required at x = 258, 2 cycles later: valid_pixel = 1, rgb = FFFF00.
  - Required at x = 256: valid_pixel = 0 (point at 0 only).
- **Priority/enable:**
  - Setup: RAM0[5] = RAM1[5] = 100, prev samples equal; dot mode; y = 200.
  - ch_en = 11 gives FFFF00; ch_en = 10 gives 00FFFF; ch_en = 00 gives valid_pixel = 0.
- **Buffer switch:**
  - Toggle read_index to 1 mid-frame: read_address MSB stays 0.
  - Present x = 0, y = 0, valid = 1: from the next cycle read_address = {1, col}, e.g. x = 766 gives address 9'h1FF.
- **Fill mode:** RAM0[10] = 40 at x = 276/277. Required: ys = 40, 90 and 128 give a hit; ys = 39 and 129 give no hit.
- **Window edges:**
  - x = 255, x = 768 and y = 512 (in_y false) give valid_pixel = 0.
  - x = 767 gives a hit when the trace covers ys.
  - Column 0 of the next line does not link to column 255 of the previous line.

Source files
------------

// File: rtl/wave_display_multi.sv
// Multi-channel waveform renderer: reads per-channel sample RAMs per pixel
// and emits a registered trace hit flag and a priority-resolved colour.
//
// Ports:
//   clk, reset (async, active-low)
//   x[10:0], y[9:0], valid   : pixel coordinate and active-area flag
//   read_index               : finished buffer, sampled at frame start
//   mode[1:0]                : 0/3 line, 1 dot, 2 fill
//   ch_en[NUM_CH-1:0]        : live per-channel enable
//   read_address             : per-channel RAM address (all identical)
//   read_value               : per-channel RAM data, one clk after address
//   valid_pixel, r, g, b     : registered pixel result
module wave_display_multi #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 9,
  parameter int X_START  = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [10:0]                  x,
  input  logic [9:0]                   y,
  input  logic                         valid,
  input  logic                         read_index,
  input  logic [1:0]                   mode,
  input  logic [NUM_CH-1:0]            ch_en,
  output logic [NUM_CH*ADDR_W-1:0]     read_address,
  input  logic [NUM_CH*SAMPLE_W-1:0]   read_value,
  output logic                         valid_pixel,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b
);

  localparam int CW = ADDR_W - 1;
  localparam logic [SAMPLE_W-1:0] MID =
    {1'b1, {(SAMPLE_W-1){1'b0}}};

  function automatic logic [23:0] pal(input int k);
    logic [23:0] c;
    c = 24'h000000;
    unique case (1'b1)
      (k == 0): c = 24'hFFFF00;
      (k == 1): c = 24'h00FFFF;
      (k == 2): c = 24'hFF00FF;
      default:  c = 24'h00FF00;
    endcase
    return c;
  endfunction

  function automatic logic on_trace(
    input logic [1:0]          m,
    input logic [SAMPLE_W-1:0] p,
    input logic [SAMPLE_W-1:0] c,
    input logic [SAMPLE_W-1:0] s
  );
    logic [SAMPLE_W-1:0] lo, hi, flo, fhi;
    logic                t;
    lo  = (p < c) ? p : c;
    hi  = (p < c) ? c : p;
    flo = (c < MID) ? c : MID;
    fhi = (c < MID) ? MID : c;
    t   = 1'b0;
    unique case (1'b1)
      (m == 2'd1): t = (s == c);
      (m == 2'd2): t = (s >= flo) && (s <= fhi);
      default:     t = (s >= lo) && (s <= hi);
    endcase
    return t;
  endfunction

  logic [10:0]         xo;
  logic                in_win, in_y, frame_start, new_col;
  logic [CW-1:0]       col;
  logic [SAMPLE_W-1:0] ys;
  logic [ADDR_W-1:0]   addr;

  logic                buf_sel_q;
  logic [CW-1:0]       last_col_q;
  logic                in_win_q, in_y_q, new_col_q, first_q;
  logic [SAMPLE_W-1:0] ys_q;

  logic [SAMPLE_W-1:0] prev_q [NUM_CH];
  logic [SAMPLE_W-1:0] cur_q  [NUM_CH];
  logic [SAMPLE_W-1:0] prev_d [NUM_CH];
  logic [SAMPLE_W-1:0] cur_d  [NUM_CH];
  logic [NUM_CH-1:0]   hit;

  logic                vp_d, vp_q;
  logic [23:0]         rgb_d, rgb_q;

  logic [1:0]          unused_bits;
  assign unused_bits = {xo[0], y[0]};

  assign xo     = x - 11'(X_START);
  assign in_win = valid && (x >= 11'(X_START)) &&
                  ((xo >> ADDR_W) == '0);
  assign col    = xo[ADDR_W-1:1];
  assign ys     = y[SAMPLE_W:1];
  assign in_y   = ((y >> (SAMPLE_W + 1)) == '0);

  assign addr = {buf_sel_q, in_win ? col : {CW{1'b0}}};
  assign read_address = {NUM_CH{addr}};

  assign frame_start = valid && (x == '0) && (y == '0);
  // column 0 always reloads so a line never links to the previous line
  assign new_col = in_win &&
                   ((col == '0) || (col != last_col_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_sel_q  <= 1'b0;
      last_col_q <= '0;
      in_win_q   <= 1'b0;
      in_y_q     <= 1'b0;
      new_col_q  <= 1'b0;
      first_q    <= 1'b0;
      ys_q       <= '0;
    end else begin
      if (frame_start) buf_sel_q <= read_index;
      if (new_col) last_col_q <= col;
      in_win_q  <= in_win;
      in_y_q    <= in_y;
      new_col_q <= new_col;
      first_q   <= (col == '0);
      ys_q      <= ys;
    end
  end

  // read_value belongs to the pixel held in stage 1
  always_comb begin
    prev_d = prev_q;
    cur_d  = cur_q;
    hit    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (new_col_q) begin
        prev_d[k] = first_q ?
          read_value[k*SAMPLE_W +: SAMPLE_W] : cur_q[k];
        cur_d[k]  = read_value[k*SAMPLE_W +: SAMPLE_W];
      end
      hit[k] = ch_en[k] && in_win_q && in_y_q &&
               on_trace(mode, prev_d[k], cur_d[k], ys_q);
    end
  end

  always_comb begin
    vp_d  = 1'b0;
    rgb_d = 24'h000000;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (hit[k]) begin
        vp_d  = 1'b1;
        rgb_d = pal(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        prev_q[k] <= '0;
        cur_q[k]  <= '0;
      end
      vp_q  <= 1'b0;
      rgb_q <= 24'h000000;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        prev_q[k] <= prev_d[k];
        cur_q[k]  <= cur_d[k];
      end
      vp_q  <= vp_d;
      rgb_q <= rgb_d;
    end
  end

  assign valid_pixel = vp_q;
  assign r = rgb_q[23:16];
  assign g = rgb_q[15:8];
  assign b = rgb_q[7:0];

endmodule

// File: tb/tb_wave_display_multi.sv
// Bench for wave_display_multi: sample RAM model, pixel-level
// reference model, directed cases and a randomized raster sweep.
module tb_wave_display_multi;

  localparam int NCH = 2;
  localparam int SW  = 8;
  localparam int AW  = 9;
  localparam int XS  = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [10:0]       x = '0;
  logic [9:0]        y = '0;
  logic              valid = 1'b0;
  logic              read_index = 1'b0;
  logic [1:0]        mode = '0;
  logic [NCH-1:0]    ch_en = '0;
  logic [NCH*AW-1:0] ra;
  logic [NCH*SW-1:0] rv = '0;
  logic              valid_pixel;
  logic [7:0]        r, g, b;

  always #5 clk = ~clk;

  wave_display_multi #(
    .NUM_CH(NCH), .SAMPLE_W(SW),
    .ADDR_W(AW), .X_START(XS)
  ) dut (
    .clk(clk), .reset(reset),
    .x(x), .y(y), .valid(valid),
    .read_index(read_index), .mode(mode),
    .ch_en(ch_en), .read_address(ra),
    .read_value(rv), .valid_pixel(valid_pixel),
    .r(r), .g(g), .b(b)
  );

  logic [SW-1:0] mem [NCH][1<<AW];

  always @(posedge clk)
    for (int k = 0; k < NCH; k++)
      rv[k*SW +: SW] <= mem[k][ra[k*AW +: AW]];

  typedef struct {
    logic        vp;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_buf, m_last;
  int   m_prev [NCH];
  int   m_cur  [NCH];
  logic        obs_vp;
  logic [23:0] obs_rgb;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] colour(input int k);
    case (k)
      0:       return 24'hFFFF00;
      1:       return 24'h00FFFF;
      2:       return 24'hFF00FF;
      default: return 24'h00FF00;
    endcase
  endfunction

  task automatic m_reset();
    m_buf  = 0;
    m_last = 0;
    for (int k = 0; k < NCH; k++) begin
      m_prev[k] = 0;
      m_cur[k]  = 0;
    end
    q.delete();
  endtask

  // compare the pixel from two cycles ago, then present a new one
  task automatic do_pix(input int xv, input int yv,
                        input bit vv);
    exp_t e;
    int   col, ys, a, lo, hi, c, flo, fhi;
    bit   win, iny, t;
    logic [NCH*AW-1:0] eb;
    if (q.size() == 2) begin
      e = q.pop_front();
      obs_vp  = valid_pixel;
      obs_rgb = {r, g, b};
      check("pix_vp", 64'(obs_vp), 64'(e.vp));
      check("pix_rgb", 64'(obs_rgb), 64'(e.rgb));
    end
    x = 11'(xv);
    y = 10'(yv);
    valid = vv;
    win = vv && xv >= XS && (xv - XS) < (1 << AW);
    col = win ? (xv - XS) / 2 : 0;
    a   = m_buf * (1 << (AW - 1)) + col;
    ys  = (yv / 2) % 256;
    iny = yv < 512;
    if (win && (col == 0 || col != m_last)) begin
      for (int k = 0; k < NCH; k++) begin
        m_prev[k] = (col == 0) ? int'(mem[k][a]) : m_cur[k];
        m_cur[k]  = int'(mem[k][a]);
      end
      m_last = col;
    end
    e.vp  = 1'b0;
    e.rgb = 24'h0;
    for (int k = NCH - 1; k >= 0; k--) begin
      c   = m_cur[k];
      lo  = (m_prev[k] < c) ? m_prev[k] : c;
      hi  = (m_prev[k] < c) ? c : m_prev[k];
      flo = (c < 128) ? c : 128;
      fhi = (c < 128) ? 128 : c;
      case (mode)
        2'd1:    t = (ys == c);
        2'd2:    t = (ys >= flo) && (ys <= fhi);
        default: t = (ys >= lo) && (ys <= hi);
      endcase
      if (ch_en[k] && win && iny && t) begin
        e.vp  = 1'b1;
        e.rgb = colour(k);
      end
    end
    if (vv && xv == 0 && yv == 0) m_buf = int'(read_index);
    q.push_back(e);
    for (int k = 0; k < NCH; k++)
      eb[k*AW +: AW] = AW'(a);
    #1;
    check("addr", 64'(ra), 64'(eb));
  endtask

  task automatic step(input int xv, input int yv,
                      input bit vv);
    @(negedge clk);
    do_pix(xv, yv, vv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 600, 1'b0);
  endtask

  initial begin
    int fy [5];
    bit fh [5];
    int ly, yv;
    bit en_ok;

    for (int k = 0; k < NCH; k++)
      for (int i = 0; i < (1 << AW); i++)
        mem[k][i] = '0;
    m_reset();

    // reset held with a live in-window pixel
    valid = 1'b1; x = 11'd300; y = 10'd200;
    mode = 2'd0; ch_en = 2'b11;
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_vp", 64'(valid_pixel), 64'd0);
      check("rst_rgb", 64'({r, g, b}), 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    check("rel0_vp", 64'(valid_pixel), 64'd0);
    m_reset();
    do_pix(300, 200, 1'b1);
    @(negedge clk);
    check("rel1_vp", 64'(valid_pixel), 64'd0);
    check("rel1_rgb", 64'({r, g, b}), 64'd0);
    do_pix(0, 600, 1'b0);
    idle(2);

    // line mode, two channels
    mem[0][0] = 8'd0;
    mem[0][1] = 8'd255;
    step(256, 400, 1'b1);
    step(257, 400, 1'b1);
    step(258, 400, 1'b1);
    check("line256_vp", 64'(obs_vp), 64'd0);
    idle(2);
    check("line258_vp", 64'(obs_vp), 64'd1);
    check("line258_rgb", 64'(obs_rgb), 64'hFFFF00);

    // priority and enable in dot mode
    mem[0][4] = 8'd100; mem[0][5] = 8'd100;
    mem[1][4] = 8'd100; mem[1][5] = 8'd100;
    mode = 2'd1;
    ch_en = 2'b11;
    step(264, 200, 1'b1); step(266, 200, 1'b1); idle(2);
    check("pri11_rgb", 64'(obs_rgb), 64'hFFFF00);
    ch_en = 2'b10;
    step(264, 200, 1'b1); step(266, 200, 1'b1); idle(2);
    check("pri10_rgb", 64'(obs_rgb), 64'h00FFFF);
    ch_en = 2'b00;
    step(264, 200, 1'b1); step(266, 200, 1'b1); idle(2);
    check("pri00_vp", 64'(obs_vp), 64'd0);

    // fill mode around the midline
    mem[0][10] = 8'd40;
    mode = 2'd2;
    ch_en = 2'b01;
    fy = '{40, 90, 128, 39, 129};
    fh = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step((i % 2 == 0) ? 276 : 277, 2 * fy[i], 1'b1);
      idle(2);
      check($sformatf("fill_ys%0d", fy[i]),
            64'(obs_vp), 64'(fh[i]));
    end

    // window edges
    mode = 2'd1;
    mem[0][254] = 8'd0;
    mem[0][255] = 8'd0;
    step(255, 0, 1'b1); idle(2);
    check("win255_vp", 64'(obs_vp), 64'd0);
    step(768, 0, 1'b1); idle(2);
    check("win768_vp", 64'(obs_vp), 64'd0);
    step(767, 512, 1'b1); idle(2);
    check("y512_vp", 64'(obs_vp), 64'd0);
    step(767, 0, 1'b1); idle(2);
    check("win767_vp", 64'(obs_vp), 64'd1);

    // no link from column 255 into column 0
    mode = 2'd0;
    mem[0][255] = 8'd200;
    mem[0][0]   = 8'd10;
    step(765, 200, 1'b1);
    step(767, 200, 1'b1);
    step(256, 200, 1'b1);
    idle(1);
    check("link767_vp", 64'(obs_vp), 64'd1);
    idle(1);
    check("nolink0_vp", 64'(obs_vp), 64'd0);

    // buffer switch only at frame start
    read_index = 1'b1;
    step(300, 5, 1'b1);
    check("buf_mid", 64'(ra[AW-1]), 64'd0);
    step(0, 0, 1'b1);
    step(766, 5, 1'b1);
    check("buf_sw", 64'(ra[AW-1:0]), 64'h1FF);
    idle(2);

    // randomized raster sweep
    for (int k = 0; k < NCH; k++)
      for (int i = 0; i < (1 << AW); i++)
        mem[k][i] = SW'($urandom);
    for (int ln = 0; ln < 12; ln++) begin
      idle(2);
      mode  = 2'($urandom % 4);
      ch_en = NCH'($urandom % (1 << NCH));
      if ($urandom % 3 == 0) begin
        read_index = 1'($urandom % 2);
        step(0, 0, 1'b1);
      end
      ly = $urandom % 540;
      for (int xv = 250; xv < 776; xv++) begin
        if ($urandom % 64 == 0)
          read_index = 1'($urandom % 2);
        yv = ($urandom % 4 == 0) ? int'($urandom % 540) : ly;
        en_ok = ($urandom % 8) != 0;
        step(xv, yv, en_ok);
      end
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
